// File: rtl/bitty_pkg.sv
// Shared constants and loader state encoding for the bitty instruction memory
// and its program loader.
package bitty_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  // DEPTH must equal 2**ADDR_W; the instruction memory uses the same constants.
  localparam int DEPTH  = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_WRITE,
    ST_DONE
  } loader_state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   count_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/bitty_prog_loader_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments keep the two stages a true shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bitty_prog_loader.sv
// Byte-wise program loader: four-phase host handshake, big-endian word assembly,
// sequential writes into the bitty instruction RAM while the core is held.
module bitty_prog_loader
  import bitty_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              byte_strobe,
  input  logic [7:0]        byte_in,
  output logic              byte_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow,
  output logic              err_partial
);

  logic          load_en_s;
  logic          strobe_s;
  logic          strobe_s_d;
  logic          str_rise;
  logic          room;
  logic [7:0]    hi_byte;
  loader_state_t state;

  sync2 u_sync_en (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (load_en),
    .q     (load_en_s)
  );

  sync2 u_sync_strobe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (byte_strobe),
    .q     (strobe_s)
  );

  assign str_rise = strobe_s & ~strobe_s_d;
  assign room     = (word_count < count_t'(DEPTH));

  // Session end is taken from the synchronised level rather than a one-cycle
  // fall pulse, so a load_en drop that lands in WRITE is still honoured in WAIT_HI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      strobe_s_d   <= 1'b0;
      hi_byte      <= '0;
      byte_ack     <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      core_hold    <= 1'b0;
      load_done    <= 1'b0;
      word_count   <= '0;
      err_overflow <= 1'b0;
      err_partial  <= 1'b0;
    end else begin
      strobe_s_d <= strobe_s;
      mem_we     <= 1'b0;
      load_done  <= 1'b0;

      // Ack every strobe so the host never stalls, even if the byte is discarded.
      if (str_rise) begin
        byte_ack <= 1'b1;
      end else if (!strobe_s) begin
        byte_ack <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          core_hold <= 1'b0;
          if (load_en_s) begin
            word_count   <= '0;
            mem_waddr    <= '0;
            err_overflow <= 1'b0;
            err_partial  <= 1'b0;
            hi_byte      <= '0;
            core_hold    <= 1'b1;
            state        <= ST_WAIT_HI;
          end
        end

        ST_WAIT_HI: begin
          if (!load_en_s) begin
            core_hold <= 1'b0;
            load_done <= 1'b1;
            state     <= ST_DONE;
          end else if (str_rise) begin
            hi_byte <= byte_in;
            state   <= ST_WAIT_LO;
          end
        end

        ST_WAIT_LO: begin
          // A coincident strobe edge loses to the session end; the byte is dropped.
          if (!load_en_s) begin
            err_partial <= 1'b1;
            hi_byte     <= '0;
            core_hold   <= 1'b0;
            load_done   <= 1'b1;
            state       <= ST_DONE;
          end else if (str_rise) begin
            if (room) begin
              mem_we    <= 1'b1;
              mem_wdata <= {hi_byte, byte_in};
            end
            state <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          // mem_we is high this cycle with the current mem_waddr; advance afterwards.
          if (room) begin
            word_count <= word_count + count_t'(1);
            if (mem_waddr != addr_t'(DEPTH - 1)) begin
              mem_waddr <= mem_waddr + addr_t'(1);
            end
          end else begin
            err_overflow <= 1'b1;
          end
          state <= ST_WAIT_HI;
        end

        ST_DONE: begin
          core_hold <= 1'b0;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_prog_loader.sv
// Directed self-checking bench for bitty_prog_loader.
module tb_bitty_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic       byte_strobe;
  logic [7:0] byte_in;
  logic       byte_ack;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic       core_hold;
  logic       load_done;
  logic [8:0] word_count;
  logic       err_overflow;
  logic       err_partial;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wa_q[$];
  logic [15:0] wd_q[$];
  int          done_cnt = 0;

  bitty_prog_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (load_en),
    .byte_strobe  (byte_strobe),
    .byte_in      (byte_in),
    .byte_ack     (byte_ack),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .word_count   (word_count),
    .err_overflow (err_overflow),
    .err_partial  (err_partial)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_waddr);
      wd_q.push_back(mem_wdata);
    end
    if (load_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input logic level, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (byte_ack === level) begin
        n = i;
        break;
      end
    end
    if (n == 0) check("ack_timeout", {31'd0, byte_ack}, {31'd0, level});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(posedge clk); #1;
    byte_in     = b;
    byte_strobe = 1'b1;
    wait_ack(1'b1, n);
    byte_strobe = 1'b0;
    wait_ack(1'b0, n);
  endtask

  task automatic start_session();
    @(posedge clk); #1;
    load_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic end_session();
    @(posedge clk); #1;
    load_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},  {31'd0, byte_ack},     32'd0);
    check({tag, "_we"},   {31'd0, mem_we},       32'd0);
    check({tag, "_addr"}, {24'd0, mem_waddr},    32'd0);
    check({tag, "_data"}, {16'd0, mem_wdata},    32'd0);
    check({tag, "_hold"}, {31'd0, core_hold},    32'd0);
    check({tag, "_done"}, {31'd0, load_done},    32'd0);
    check({tag, "_wc"},   {23'd0, word_count},   32'd0);
    check({tag, "_ovf"},  {31'd0, err_overflow}, 32'd0);
    check({tag, "_part"}, {31'd0, err_partial},  32'd0);
  endtask

  initial begin
    int wbase;
    int dbase;
    int n;
    logic [15:0] t1_data[3];
    logic [7:0]  b;

    t1_data[0] = 16'h1234;
    t1_data[1] = 16'hABCD;
    t1_data[2] = 16'h0001;

    rst_n       = 1'b0;
    load_en     = 1'b0;
    byte_strobe = 1'b0;
    byte_in     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // 1: three words, hi byte first
    wbase = wa_q.size();
    dbase = done_cnt;
    start_session();
    check("t1_hold_on", {31'd0, core_hold}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      send_byte(t1_data[i][15:8]);
      send_byte(t1_data[i][7:0]);
    end
    end_session();
    check("t1_nwrites", wa_q.size() - wbase, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (wa_q.size() > wbase + i) begin
        check($sformatf("t1_addr%0d", i), {24'd0, wa_q[wbase+i]}, i);
        check($sformatf("t1_data%0d", i), {16'd0, wd_q[wbase+i]}, {16'd0, t1_data[i]});
      end
    end
    check("t1_wc",   {23'd0, word_count},   32'd3);
    check("t1_done", done_cnt - dbase,      32'd1);
    check("t1_ovf",  {31'd0, err_overflow}, 32'd0);
    check("t1_part", {31'd0, err_partial},  32'd0);
    check("t1_hold_off", {31'd0, core_hold}, 32'd0);

    // 2: handshake timing, one capture per strobe pulse
    wbase = wa_q.size();
    dbase = done_cnt;
    start_session();
    @(posedge clk); #1;
    byte_in     = 8'h5A;
    byte_strobe = 1'b1;
    wait_ack(1'b1, n);
    check("t2_ack_rise_clks", n, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    check("t2_ack_held", {31'd0, byte_ack}, 32'd1);
    byte_strobe = 1'b0;
    wait_ack(1'b0, n);
    check("t2_ack_fall_clks", n, 32'd3);
    check("t2_no_write_yet", wa_q.size() - wbase, 32'd0);
    send_byte(8'hA5);
    end_session();
    check("t2_nwrites", wa_q.size() - wbase, 32'd1);
    if (wa_q.size() > wbase) begin
      check("t2_addr", {24'd0, wa_q[wbase]}, 32'd0);
      check("t2_data", {16'd0, wd_q[wbase]}, 32'h5AA5);
    end
    check("t2_done", done_cnt - dbase, 32'd1);

    // 3: hi byte only
    wbase = wa_q.size();
    dbase = done_cnt;
    start_session();
    send_byte(8'h77);
    check("t3_hold_on", {31'd0, core_hold}, 32'd1);
    end_session();
    check("t3_part",     {31'd0, err_partial}, 32'd1);
    check("t3_nwrites",  wa_q.size() - wbase,  32'd0);
    check("t3_done",     done_cnt - dbase,     32'd1);
    check("t3_hold_off", {31'd0, core_hold},   32'd0);
    check("t3_wc",       {23'd0, word_count},  32'd0);

    // 4: 257 words; the last one overflows
    wbase = wa_q.size();
    dbase = done_cnt;
    start_session();
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      send_byte(~b);
      send_byte(b);
    end
    check("t4_ovf_at_256", {31'd0, err_overflow}, 32'd0);
    check("t4_wc_256",     {23'd0, word_count},   32'd256);
    check("t4_addr_sat",   {24'd0, mem_waddr},    32'd255);
    send_byte(8'hFF);
    send_byte(8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("t4_ovf", {31'd0, err_overflow}, 32'd1);
    check("t4_wc",  {23'd0, word_count},   32'd256);
    end_session();
    check("t4_nwrites", wa_q.size() - wbase, 32'd256);
    for (int i = 0; i < 256; i++) begin
      if (wa_q.size() > wbase + i) begin
        b = i[7:0];
        check($sformatf("t4_addr%0d", i), {24'd0, wa_q[wbase+i]}, i);
        check($sformatf("t4_data%0d", i), {16'd0, wd_q[wbase+i]}, {16'd0, ~b, b});
      end
    end
    check("t4_ovf_sticky", {31'd0, err_overflow}, 32'd1);
    check("t4_done",       done_cnt - dbase,      32'd1);

    // 5: reset in WAIT_LO, then a clean session from address 0
    start_session();
    send_byte(8'hEE);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wbase = wa_q.size();
    dbase = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    send_byte(8'h12);
    send_byte(8'h34);
    end_session();
    check("t5_nwrites", wa_q.size() - wbase, 32'd1);
    if (wa_q.size() > wbase) begin
      check("t5_addr", {24'd0, wa_q[wbase]}, 32'd0);
      check("t5_data", {16'd0, wd_q[wbase]}, 32'h1234);
    end
    check("t5_done", done_cnt - dbase, 32'd1);
    check("t5_part", {31'd0, err_partial}, 32'd0);

    // 6: lo-byte strobe coincident with load_en fall
    wbase = wa_q.size();
    dbase = done_cnt;
    start_session();
    send_byte(8'h99);
    @(posedge clk); #1;
    byte_in     = 8'h66;
    byte_strobe = 1'b1;
    load_en     = 1'b0;
    wait_ack(1'b1, n);
    byte_strobe = 1'b0;
    wait_ack(1'b0, n);
    repeat (6) @(posedge clk);
    #1;
    check("t6_nwrites", wa_q.size() - wbase,  32'd0);
    check("t6_part",    {31'd0, err_partial}, 32'd1);
    check("t6_done",    done_cnt - dbase,     32'd1);
    check("t6_hold",    {31'd0, core_hold},   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
